// File: rtl/axi4_copy_pkg.sv
// Shared types and constants for the AXI4 burst copier.
package axi4_copy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_DATA,
    WR_RESP
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // AxSIZE encoding: log2 of the number of bytes per beat.
  function automatic logic [2:0] axi_size(input int data_width);
    int          bytes;
    logic [2:0]  size;
    bytes = data_width / 8;
    size  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) == bytes) size = 3'(i);
    end
    return size;
  endfunction

endpackage

// File: rtl/copy_buffer.sv
// Chunk staging buffer: register file with synchronous write and
// combinational read, so W beats can stream back-to-back.
module copy_buffer #(
  parameter int G_DEPTH      = 4,
  parameter int G_DATA_WIDTH = 32,
  parameter int G_IDX_WIDTH  = 2
) (
  input  logic                    clock,
  input  logic                    wr_en,
  input  logic [G_IDX_WIDTH-1:0]  wr_idx,
  input  logic [G_DATA_WIDTH-1:0] wr_data,
  input  logic [G_IDX_WIDTH-1:0]  rd_idx,
  output logic [G_DATA_WIDTH-1:0] rd_data
);

  logic [G_DATA_WIDTH-1:0] mem_q [G_DEPTH];
  logic [G_DATA_WIDTH-1:0] mem_d [G_DEPTH];

  // Next contents: overwrite the addressed entry on a write.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_idx] = wr_data;
  end

  // Storage; data only, so no reset.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/axi4_burst_copier.sv
// AXI4 master copy engine: moves cmd_words words from cmd_src to cmd_dst
// in chunks of up to G_MAX_BURST beats, one INCR read burst then one INCR
// write burst per chunk, never overlapping read and write traffic.
// Optional build macro AXI4_COPY_RESP_CHECK_EN adds a sticky err output
// (bad RRESP/RLAST or BRESP); a bad BRESP also aborts the command.
module axi4_burst_copier
  import axi4_copy_pkg::*;
#(
  parameter int G_ADDR_WIDTH = 6,
  parameter int G_DATA_WIDTH = 32,
  parameter int G_ID_WIDTH   = 2,
  parameter int G_ID         = 0,
  parameter int G_MAX_BURST  = 4,
  parameter int G_CNT_WIDTH  = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [G_ADDR_WIDTH-1:0]   cmd_src,
  input  logic [G_ADDR_WIDTH-1:0]   cmd_dst,
  input  logic [G_CNT_WIDTH-1:0]    cmd_words,
  output logic                      busy,
  output logic                      done,
`ifdef AXI4_COPY_RESP_CHECK_EN
  output logic                      err,
`endif
  output logic                      m_arvalid,
  input  logic                      m_arready,
  output logic [G_ID_WIDTH-1:0]     m_arid,
  output logic [G_ADDR_WIDTH-1:0]   m_araddr,
  output logic [7:0]                m_arlen,
  output logic [2:0]                m_arsize,
  output logic [1:0]                m_arburst,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  input  logic [G_DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rlast,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [G_ID_WIDTH-1:0]     m_awid,
  output logic [G_ADDR_WIDTH-1:0]   m_awaddr,
  output logic [7:0]                m_awlen,
  output logic [2:0]                m_awsize,
  output logic [1:0]                m_awburst,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  output logic [G_DATA_WIDTH-1:0]   m_wdata,
  output logic [G_DATA_WIDTH/8-1:0] m_wstrb,
  output logic                      m_wlast,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  input  logic [1:0]                m_bresp
);

  localparam int         IW   = (G_MAX_BURST > 1) ? $clog2(G_MAX_BURST) : 1;
  localparam int         CW   = (G_CNT_WIDTH > 9) ? G_CNT_WIDTH : 9;
  localparam logic [2:0] SIZE = axi_size(G_DATA_WIDTH);

  state_t                  state_q, state_d;
  logic [G_ADDR_WIDTH-1:0] src_q, src_d;
  logic [G_ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [G_CNT_WIDTH-1:0]  rem_q, rem_d;
  logic [IW-1:0]           beat_q, beat_d;
  logic                    done_q, done_d;
`ifdef AXI4_COPY_RESP_CHECK_EN
  logic                    err_q, err_d;
`else
  logic                    unused_resp;
  assign unused_resp = ^{m_rresp, m_rlast, m_bresp};
`endif

  logic [CW-1:0]           chunk_w;
  logic                    last_beat;
  logic                    buf_we;
  logic [G_DATA_WIDTH-1:0] buf_rdata;

  // Chunk only depends on remaining count, which is stable for a whole chunk.
  assign chunk_w   = (CW'(rem_q) >= CW'(G_MAX_BURST)) ? CW'(G_MAX_BURST) : CW'(rem_q);
  assign last_beat = (CW'(beat_q) == (chunk_w - CW'(1)));
  assign buf_we    = (state_q == RD_DATA) && m_rvalid;

  copy_buffer #(
    .G_DEPTH      (G_MAX_BURST),
    .G_DATA_WIDTH (G_DATA_WIDTH),
    .G_IDX_WIDTH  (IW)
  ) u_buf (
    .clock   (clock),
    .wr_en   (buf_we),
    .wr_idx  (beat_q),
    .wr_data (m_rdata),
    .rd_idx  (beat_q),
    .rd_data (buf_rdata)
  );

  // State and control registers; reset abandons any transfer in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      beat_q  <= '0;
      done_q  <= 1'b0;
`ifdef AXI4_COPY_RESP_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
`ifdef AXI4_COPY_RESP_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next-state and datapath update; beats are counted, RLAST never steers.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    beat_d  = beat_q;
    done_d  = 1'b0;
`ifdef AXI4_COPY_RESP_CHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
`ifdef AXI4_COPY_RESP_CHECK_EN
          err_d = 1'b0;
`endif
          if (cmd_words != '0) begin
            src_d   = cmd_src;
            dst_d   = cmd_dst;
            rem_d   = cmd_words;
            beat_d  = '0;
            state_d = RD_ADDR;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RD_ADDR: if (m_arready) state_d = RD_DATA;
      RD_DATA: begin
        if (m_rvalid) begin
`ifdef AXI4_COPY_RESP_CHECK_EN
          if ((m_rresp != RESP_OKAY) || (m_rlast != last_beat)) err_d = 1'b1;
`endif
          if (last_beat) begin
            beat_d  = '0;
            state_d = WR_ADDR;
          end else begin
            beat_d = beat_q + IW'(1);
          end
        end
      end
      WR_ADDR: if (m_awready) state_d = WR_DATA;
      WR_DATA: begin
        if (m_wready) begin
          if (last_beat) begin
            beat_d  = '0;
            state_d = WR_RESP;
          end else begin
            beat_d = beat_q + IW'(1);
          end
        end
      end
      WR_RESP: begin
        if (m_bvalid) begin
`ifdef AXI4_COPY_RESP_CHECK_EN
          if (m_bresp != RESP_OKAY) begin
            err_d   = 1'b1;
            rem_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else
`endif
          begin
            src_d = src_q + (G_ADDR_WIDTH'(chunk_w) << SIZE);
            dst_d = dst_q + (G_ADDR_WIDTH'(chunk_w) << SIZE);
            rem_d = rem_q - G_CNT_WIDTH'(chunk_w);
            if (rem_q == G_CNT_WIDTH'(chunk_w)) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = RD_ADDR;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // AXI and command outputs decoded from the current state.
  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    done      = done_q;
    m_arvalid = (state_q == RD_ADDR);
    m_arid    = G_ID_WIDTH'(G_ID);
    m_araddr  = src_q;
    m_arlen   = 8'(chunk_w - CW'(1));
    m_arsize  = SIZE;
    m_arburst = BURST_INCR;
    m_rready  = (state_q == RD_DATA);
    m_awvalid = (state_q == WR_ADDR);
    m_awid    = G_ID_WIDTH'(G_ID);
    m_awaddr  = dst_q;
    m_awlen   = 8'(chunk_w - CW'(1));
    m_awsize  = SIZE;
    m_awburst = BURST_INCR;
    m_wvalid  = (state_q == WR_DATA);
    m_wdata   = buf_rdata;
    m_wstrb   = '1;
    m_wlast   = (state_q == WR_DATA) && last_beat;
    m_bready  = (state_q == WR_RESP);
  end

`ifdef AXI4_COPY_RESP_CHECK_EN
  assign err = err_q;
`endif

endmodule

// File: tb/tb_axi4_burst_copier.sv
// Directed bench for axi4_burst_copier with a small AXI4 slave memory model
// (16 x 32-bit words, late ARREADY, serialized traffic).
module tb_axi4_burst_copier;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [5:0]  cmd_src = '0;
  logic [5:0]  cmd_dst = '0;
  logic [7:0]  cmd_words = '0;
  logic        busy, done;
`ifdef AXI4_COPY_RESP_CHECK_EN
  logic        err;
`endif
  logic        m_arvalid, m_arready;
  logic [1:0]  m_arid, m_awid;
  logic [5:0]  m_araddr, m_awaddr;
  logic [7:0]  m_arlen, m_awlen;
  logic [2:0]  m_arsize, m_awsize;
  logic [1:0]  m_arburst, m_awburst;
  logic        m_rvalid, m_rready, m_rlast;
  logic [31:0] m_rdata, m_wdata;
  logic [1:0]  m_rresp, m_bresp;
  logic        m_awvalid, m_awready;
  logic        m_wvalid, m_wready, m_wlast;
  logic [3:0]  m_wstrb;
  logic        m_bvalid, m_bready;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  axi4_burst_copier dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_words(cmd_words),
    .busy(busy), .done(done),
`ifdef AXI4_COPY_RESP_CHECK_EN
    .err(err),
`endif
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp)
  );

  // ---------------- slave memory model ----------------
  logic [31:0] mem [16];
  logic        s_arready, s_awready;
  logic [1:0]  ar_wait;
  logic        rd_active, wr_active, b_pend;
  logic [5:0]  rd_addr, wr_addr;
  logic [7:0]  rd_left;
  logic [1:0]  force_bresp = 2'b00;
  int          ar_cnt = 0, aw_cnt = 0, wbeat_cnt = 0, wlast_cnt = 0, ovl_cnt = 0;
  int          done_cnt = 0;
  logic [5:0]  ar_addr_log [16];
  logic [7:0]  ar_len_log  [16];
  logic [5:0]  aw_addr_log [16];
  logic [7:0]  aw_len_log  [16];

  assign m_arready = s_arready;
  assign m_awready = s_awready;
  assign m_rvalid  = rd_active;
  assign m_rdata   = mem[rd_addr[5:2]];
  assign m_rlast   = rd_active && (rd_left == 8'd0);
  assign m_rresp   = 2'b00;
  assign m_wready  = wr_active;
  assign m_bvalid  = b_pend;
  assign m_bresp   = force_bresp;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      s_arready <= 1'b0; ar_wait <= '0; rd_active <= 1'b0; rd_addr <= '0; rd_left <= '0;
      s_awready <= 1'b0; wr_active <= 1'b0; wr_addr <= '0; b_pend <= 1'b0;
    end else begin
      if (m_arvalid && s_arready) begin
        s_arready <= 1'b0; ar_wait <= '0;
        rd_addr <= m_araddr; rd_left <= m_arlen; rd_active <= 1'b1;
        ar_addr_log[ar_cnt[3:0]] <= m_araddr;
        ar_len_log[ar_cnt[3:0]]  <= m_arlen;
        ar_cnt <= ar_cnt + 1;
      end else if (m_arvalid) begin
        if (ar_wait == 2'd2) s_arready <= 1'b1;
        else ar_wait <= ar_wait + 2'd1;
      end
      if (rd_active && m_rready) begin
        rd_addr <= rd_addr + 6'd4;
        if (rd_left == 8'd0) rd_active <= 1'b0;
        else rd_left <= rd_left - 8'd1;
      end
      if (m_awvalid && s_awready) begin
        s_awready <= 1'b0; wr_addr <= m_awaddr; wr_active <= 1'b1;
        aw_addr_log[aw_cnt[3:0]] <= m_awaddr;
        aw_len_log[aw_cnt[3:0]]  <= m_awlen;
        aw_cnt <= aw_cnt + 1;
      end else begin
        s_awready <= m_awvalid;
      end
      if (wr_active && m_wvalid) begin
        mem[wr_addr[5:2]] = m_wdata;
        wr_addr <= wr_addr + 6'd4;
        wbeat_cnt <= wbeat_cnt + 1;
        if (m_wlast) begin
          wr_active <= 1'b0; b_pend <= 1'b1; wlast_cnt <= wlast_cnt + 1;
        end
      end
      if (b_pend && m_bready) b_pend <= 1'b0;
      if ((m_arvalid || m_rready) && (m_awvalid || m_wvalid || m_bready)) ovl_cnt <= ovl_cnt + 1;
    end
  end

  always @(posedge clock) begin
    if (done) done_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic [5:0] s, input logic [5:0] d, input logic [7:0] w);
    @(negedge clock);
    cmd_src = s; cmd_dst = d; cmd_words = w; cmd_valid = 1'b1;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok, output int busy_lo);
    ok = 1'b0; busy_lo = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(posedge clock); #1;
      if (done) ok = 1'b1;
      else if (!busy) busy_lo++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_vec++; if ({m_arvalid, m_awvalid, m_wvalid} !== 3'b000) begin n_bad++; $display("FAIL rst_valids got %b want 000", {m_arvalid, m_awvalid, m_wvalid}); end
    n_vec++; if ({m_rready, m_bready} !== 2'b00) begin n_bad++; $display("FAIL rst_readys got %b want 00", {m_rready, m_bready}); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", done); end
`ifdef AXI4_COPY_RESP_CHECK_EN
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", err); end
`endif
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    #1;
    n_vec++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL idle_cmd_ready got %b want 1", cmd_ready); end
  endtask

  task automatic test_fixed_fields();
    n_vec++; if ({m_arburst, m_awburst} !== 4'b0101) begin n_bad++; $display("FAIL burst_type got %b want 0101", {m_arburst, m_awburst}); end
    n_vec++; if ({m_arsize, m_awsize} !== 6'b010010) begin n_bad++; $display("FAIL size got %b want 010010", {m_arsize, m_awsize}); end
    n_vec++; if (m_wstrb !== 4'hF) begin n_bad++; $display("FAIL wstrb got %h want f", m_wstrb); end
    n_vec++; if ({m_arid, m_awid} !== 4'b0000) begin n_bad++; $display("FAIL ids got %b want 0000", {m_arid, m_awid}); end
  endtask

  task automatic test_basic_copy();
    int a0, w0, b0, l0, d0, blo; bit ok;
    mem[0] = 32'hA0; mem[1] = 32'hA1; mem[2] = 32'hA2;
    mem[8] = '0; mem[9] = '0; mem[10] = '0;
    a0 = ar_cnt; w0 = aw_cnt; b0 = wbeat_cnt; l0 = wlast_cnt; d0 = done_cnt;
    issue(6'h00, 6'h20, 8'd3);
    wait_done(200, ok, blo);
    repeat (3) @(posedge clock); #1;
    n_vec++; if (ok !== 1'b1) begin n_bad++; $display("FAIL basic_done got timeout want done"); end
    n_vec++; if (ar_cnt - a0 !== 1) begin n_bad++; $display("FAIL basic_ar_count got %0d want 1", ar_cnt - a0); end
    n_vec++; if (aw_cnt - w0 !== 1) begin n_bad++; $display("FAIL basic_aw_count got %0d want 1", aw_cnt - w0); end
    n_vec++; if (ar_len_log[a0[3:0]] !== 8'd2) begin n_bad++; $display("FAIL basic_arlen got %0d want 2", ar_len_log[a0[3:0]]); end
    n_vec++; if (aw_len_log[w0[3:0]] !== 8'd2) begin n_bad++; $display("FAIL basic_awlen got %0d want 2", aw_len_log[w0[3:0]]); end
    n_vec++; if (aw_addr_log[w0[3:0]] !== 6'h20) begin n_bad++; $display("FAIL basic_awaddr got %h want 20", aw_addr_log[w0[3:0]]); end
    n_vec++; if (wbeat_cnt - b0 !== 3) begin n_bad++; $display("FAIL basic_wbeats got %0d want 3", wbeat_cnt - b0); end
    n_vec++; if (wlast_cnt - l0 !== 1) begin n_bad++; $display("FAIL basic_wlast got %0d want 1", wlast_cnt - l0); end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (mem[8 + i] !== 32'hA0 + 32'(i)) begin n_bad++; $display("FAIL basic_data[%0d] got %h want %h", i, mem[8 + i], 32'hA0 + 32'(i)); end
    end
    n_vec++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_multi_chunk();
    int a0, w0, blo; bit ok;
    logic [7:0] exp_len [3];
    logic [5:0] exp_ar  [3];
    logic [5:0] exp_aw  [3];
    exp_len = '{8'd3, 8'd3, 8'd1};
    exp_ar  = '{6'h00, 6'h10, 6'h20};
    exp_aw  = '{6'h28, 6'h38, 6'h08};
    for (int i = 0; i < 16; i++) mem[i] = (i < 10) ? 32'h100 + 32'(i) : 32'h0;
    a0 = ar_cnt; w0 = aw_cnt;
    issue(6'h00, 6'h28, 8'd10);
    wait_done(400, ok, blo);
    n_vec++; if (ok !== 1'b1) begin n_bad++; $display("FAIL multi_done got timeout want done"); end
    n_vec++; if (blo !== 0) begin n_bad++; $display("FAIL multi_busy_low got %0d cycles want 0", blo); end
    n_vec++; if (ar_cnt - a0 !== 3) begin n_bad++; $display("FAIL multi_ar_count got %0d want 3", ar_cnt - a0); end
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (ar_len_log[4'(a0 + k)] !== exp_len[k]) begin n_bad++; $display("FAIL multi_arlen[%0d] got %0d want %0d", k, ar_len_log[4'(a0 + k)], exp_len[k]); end
      n_vec++; if (ar_addr_log[4'(a0 + k)] !== exp_ar[k]) begin n_bad++; $display("FAIL multi_araddr[%0d] got %h want %h", k, ar_addr_log[4'(a0 + k)], exp_ar[k]); end
      n_vec++; if (aw_addr_log[4'(w0 + k)] !== exp_aw[k]) begin n_bad++; $display("FAIL multi_awaddr[%0d] got %h want %h", k, aw_addr_log[4'(w0 + k)], exp_aw[k]); end
    end
    for (int i = 0; i < 10; i++) begin
      n_vec++; if (mem[(10 + i) % 16] !== 32'h100 + 32'(i)) begin n_bad++; $display("FAIL multi_data[%0d] got %h want %h", i, mem[(10 + i) % 16], 32'h100 + 32'(i)); end
    end
    n_vec++; if (ovl_cnt !== 0) begin n_bad++; $display("FAIL rd_wr_overlap got %0d cycles want 0", ovl_cnt); end
  endtask

  task automatic test_zero_words();
    int a0, w0;
    a0 = ar_cnt; w0 = aw_cnt;
    issue(6'h04, 6'h24, 8'd0);
    n_vec++; if (done !== 1'b1) begin n_bad++; $display("FAIL zero_done got %b want 1", done); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy got %b want 0", busy); end
    @(posedge clock); #1;
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL zero_done_width got %b want 0", done); end
    repeat (4) @(posedge clock); #1;
    n_vec++; if ((ar_cnt - a0) + (aw_cnt - w0) !== 0) begin n_bad++; $display("FAIL zero_traffic got %0d bursts want 0", (ar_cnt - a0) + (aw_cnt - w0)); end
  endtask

  task automatic test_addr_wrap();
    int a0, w0, blo; bit ok;
    mem[15] = 32'hE0;
    for (int i = 0; i < 5; i++) mem[i] = 32'hE1 + 32'(i);
    for (int i = 8; i < 14; i++) mem[i] = '0;
    a0 = ar_cnt; w0 = aw_cnt;
    issue(6'h3C, 6'h20, 8'd6);
    wait_done(300, ok, blo);
    n_vec++; if (ok !== 1'b1) begin n_bad++; $display("FAIL wrap_done got timeout want done"); end
    n_vec++; if (ar_addr_log[4'(a0 + 1)] !== 6'h0C) begin n_bad++; $display("FAIL wrap_araddr2 got %h want 0c", ar_addr_log[4'(a0 + 1)]); end
    n_vec++; if (aw_addr_log[4'(w0 + 1)] !== 6'h30) begin n_bad++; $display("FAIL wrap_awaddr2 got %h want 30", aw_addr_log[4'(w0 + 1)]); end
    for (int i = 0; i < 6; i++) begin
      n_vec++; if (mem[8 + i] !== 32'hE0 + 32'(i)) begin n_bad++; $display("FAIL wrap_data[%0d] got %h want %h", i, mem[8 + i], 32'hE0 + 32'(i)); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int d0, blo; bit ok, seen;
    for (int i = 0; i < 8; i++) mem[i] = 32'h200 + 32'(i);
    issue(6'h00, 6'h20, 8'd8);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clock); #1;
      if (m_wvalid) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rstmid_wvalid got timeout want wvalid"); end
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    n_vec++; if ({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready} !== 5'b0) begin n_bad++; $display("FAIL rstmid_outputs got %b want 00000", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
    @(negedge clock); reset = 1'b0;
    d0 = done_cnt;
    repeat (10) @(posedge clock); #1;
    n_vec++; if (done_cnt - d0 !== 0) begin n_bad++; $display("FAIL rstmid_no_done got %0d pulses want 0", done_cnt - d0); end
    mem[15] = '0;
    issue(6'h04, 6'h3C, 8'd1);
    wait_done(200, ok, blo);
    n_vec++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rstmid_recover_done got timeout want done"); end
    n_vec++; if (mem[15] !== 32'h201) begin n_bad++; $display("FAIL rstmid_recover_data got %h want 201", mem[15]); end
  endtask

`ifdef AXI4_COPY_RESP_CHECK_EN
  task automatic test_bresp_abort();
    int a0, w0, blo; bit ok;
    for (int i = 0; i < 8; i++) mem[i] = 32'h300 + 32'(i);
    for (int i = 8; i < 16; i++) mem[i] = 32'hDEAD;
    a0 = ar_cnt; w0 = aw_cnt;
    force_bresp = 2'b10;
    issue(6'h00, 6'h20, 8'd8);
    wait_done(200, ok, blo);
    force_bresp = 2'b00;
    n_vec++; if (ok !== 1'b1) begin n_bad++; $display("FAIL abort_done got timeout want done"); end
    n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL abort_err got %b want 1", err); end
    n_vec++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL abort_idle got %b want 1", cmd_ready); end
    repeat (5) @(posedge clock); #1;
    n_vec++; if ((ar_cnt - a0) + (aw_cnt - w0) !== 2) begin n_bad++; $display("FAIL abort_bursts got %0d want 2", (ar_cnt - a0) + (aw_cnt - w0)); end
    n_vec++; if (mem[12] !== 32'hDEAD) begin n_bad++; $display("FAIL abort_skip got %h want dead", mem[12]); end
    issue(6'h00, 6'h00, 8'd0);
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL abort_err_clear got %b want 0", err); end
  endtask
`endif

  initial begin
    test_reset();
    test_fixed_fields();
    test_basic_copy();
    test_multi_chunk();
    test_zero_words();
    test_addr_wrap();
    test_reset_mid_burst();
`ifdef AXI4_COPY_RESP_CHECK_EN
    test_bresp_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
